// File: rtl/huff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : huff_pkg                                                   |
// | Brief    : Shared state encoding, symbol count and lmask decode for   |
// |            the Huffman byte-frequency statistics stage.               |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package huff_pkg;

    localparam int SYM_NUM = 256;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_COUNT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    // Legal byte counts are 1..4; anything else means a full word.
    function automatic logic [2:0] lmask_bytes(input logic [2:0] lmask);
        if ((lmask == 3'd0) || (lmask > 3'd4)) begin
            return 3'd4;
        end
        return lmask;
    endfunction

endpackage : huff_pkg
`default_nettype wire

// File: rtl/freq_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : freq_ram                                                   |
// | Brief    : 256 x CNT_W simple dual-port RAM, registered read port,    |
// |            no array reset so it maps onto block RAM.                  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module freq_ram
    import huff_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_addr,
    input  logic [CNT_W-1:0] i_wr_data,
    input  logic [7:0]       i_rd_addr,
    output logic [CNT_W-1:0] o_rd_data
);

    logic [CNT_W-1:0] mem [SYM_NUM];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= mem[i_rd_addr];
    end

endmodule : freq_ram
`default_nettype wire

// File: rtl/huff_freq_stat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : huff_freq_stat                                             |
// | Brief    : Counts byte frequencies per block, streams the 256 counts  |
// |            on end-of-block and clears the RAM while scanning.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module huff_freq_stat
    import huff_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TOT_W = 24
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [31:0]      huff_data,
    input  logic             huff_valid,
    input  logic [2:0]       huff_lmask,
    input  logic             in_end,
    output logic             huff_full,
    output logic [7:0]       freq_sym,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid,
    output logic             freq_last,
    input  logic             freq_ready,
    output logic [TOT_W-1:0] blk_total,
    output logic             ovf_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    state_t state_q, state_d;
    logic [8:0]       addr_q, addr_d;
    logic             huff_full_q, huff_full_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic [2:0]       buf_left_q, buf_left_d;
    logic             buf_end_q, buf_end_d;
    logic             p_valid_q, p_valid_d;
    logic [7:0]       p_sym_q, p_sym_d;
    logic             p_fwd_q, p_fwd_d;
    logic [CNT_W-1:0] last_wr_q, last_wr_d;
    logic             rd_pend_q, rd_pend_d;
    logic [7:0]       rd_sym_q, rd_sym_d;
    logic             freq_valid_q, freq_valid_d;
    logic [7:0]       freq_sym_q, freq_sym_d;
    logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
    logic             skid_valid_q, skid_valid_d;
    logic [7:0]       skid_sym_q, skid_sym_d;
    logic [CNT_W-1:0] skid_cnt_q, skid_cnt_d;
    logic [TOT_W-1:0] blk_total_q, blk_total_d;
    logic             ovf_q, ovf_d;

    logic             issue, pop, scan_rd, wr_en;
    logic [7:0]       issue_sym, rd_addr, wr_addr;
    logic [CNT_W-1:0] rd_data, wr_data, cnt_old, cnt_new;
    logic [1:0]       occ, occ_left;

    freq_ram #(.CNT_W(CNT_W)) u_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    always_comb begin
        issue     = (state_q == ST_COUNT) && (buf_left_q != 3'd0);
        issue_sym = buf_data_q[31:24];
        // The previous byte's write lands on the same edge as this read.
        cnt_old   = p_fwd_q ? last_wr_q : rd_data;
        cnt_new   = (cnt_old == CNT_MAX) ? cnt_old : cnt_old + {{(CNT_W-1){1'b0}}, 1'b1};
        pop       = freq_valid_q & freq_ready;
        occ       = {1'b0, freq_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
        occ_left  = occ - {1'b0, pop};
        // A read may only launch if its data will find a free slot.
        scan_rd   = (state_q == ST_SCAN) && !addr_q[8] && (occ_left < 2'd2);
        rd_addr   = (state_q == ST_SCAN) ? addr_q[7:0] : issue_sym;

        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1; wr_addr = addr_q[7:0]; wr_data = '0;
            end
            ST_SCAN: begin
                wr_en = rd_pend_q; wr_addr = rd_sym_q; wr_data = '0;
            end
            default: begin
                wr_en = p_valid_q; wr_addr = p_sym_q; wr_data = cnt_new;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        huff_full_d = huff_full_q;
        buf_data_d  = buf_data_q;
        buf_left_d  = buf_left_q;
        buf_end_d   = buf_end_q;
        blk_total_d = blk_total_q;
        if (issue && (blk_total_q != TOT_MAX)) begin
            blk_total_d = blk_total_q + {{(TOT_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_CLEAR: begin
                addr_d = addr_q + 9'd1;
                if (addr_q[7:0] == 8'hFF) begin
                    state_d     = ST_COUNT;
                    addr_d      = '0;
                    huff_full_d = 1'b0;
                    blk_total_d = '0;
                end
            end
            ST_COUNT: begin
                if (huff_valid && !huff_full_q) begin
                    buf_data_d  = huff_data;
                    buf_left_d  = lmask_bytes(huff_lmask);
                    buf_end_d   = in_end;
                    huff_full_d = 1'b1;
                end else if (issue) begin
                    buf_data_d = {buf_data_q[23:0], 8'h00};
                    buf_left_d = buf_left_q - 3'd1;
                    if (buf_left_q == 3'd1) begin
                        if (buf_end_q) begin
                            state_d = ST_DRAIN;
                        end else begin
                            huff_full_d = 1'b0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final write remains; it lands before the first scan read.
                state_d = ST_SCAN;
                addr_d  = '0;
            end
            ST_SCAN: begin
                if (scan_rd) begin
                    addr_d = addr_q + 9'd1;
                end
                if (pop && (freq_sym_q == 8'hFF)) begin
                    state_d     = ST_COUNT;
                    huff_full_d = 1'b0;
                    blk_total_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        p_valid_d = issue;
        p_sym_d   = issue_sym;
        p_fwd_d   = issue && p_valid_q && (issue_sym == p_sym_q);
        last_wr_d = p_valid_q ? cnt_new : last_wr_q;
        rd_pend_d = scan_rd;
        rd_sym_d  = addr_q[7:0];
        ovf_d     = ovf_q | (huff_valid & huff_full_q) | (p_valid_q & (cnt_new == CNT_MAX));

        freq_valid_d = freq_valid_q;
        freq_sym_d   = freq_sym_q;
        freq_cnt_d   = freq_cnt_q;
        skid_valid_d = skid_valid_q;
        skid_sym_d   = skid_sym_q;
        skid_cnt_d   = skid_cnt_q;
        if (pop || !freq_valid_q) begin
            if (skid_valid_q) begin
                freq_valid_d = 1'b1;
                freq_sym_d   = skid_sym_q;
                freq_cnt_d   = skid_cnt_q;
                skid_valid_d = rd_pend_q;
                skid_sym_d   = rd_sym_q;
                skid_cnt_d   = rd_data;
            end else begin
                freq_valid_d = rd_pend_q;
                if (rd_pend_q) begin
                    freq_sym_d = rd_sym_q;
                    freq_cnt_d = rd_data;
                end
            end
        end else if (rd_pend_q) begin
            skid_valid_d = 1'b1;
            skid_sym_d   = rd_sym_q;
            skid_cnt_d   = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_CLEAR;
            addr_q       <= '0;
            huff_full_q  <= 1'b1;
            buf_data_q   <= '0;
            buf_left_q   <= '0;
            buf_end_q    <= 1'b0;
            p_valid_q    <= 1'b0;
            p_sym_q      <= '0;
            p_fwd_q      <= 1'b0;
            last_wr_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_sym_q     <= '0;
            freq_valid_q <= 1'b0;
            freq_sym_q   <= '0;
            freq_cnt_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_sym_q   <= '0;
            skid_cnt_q   <= '0;
            blk_total_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            huff_full_q  <= huff_full_d;
            buf_data_q   <= buf_data_d;
            buf_left_q   <= buf_left_d;
            buf_end_q    <= buf_end_d;
            p_valid_q    <= p_valid_d;
            p_sym_q      <= p_sym_d;
            p_fwd_q      <= p_fwd_d;
            last_wr_q    <= last_wr_d;
            rd_pend_q    <= rd_pend_d;
            rd_sym_q     <= rd_sym_d;
            freq_valid_q <= freq_valid_d;
            freq_sym_q   <= freq_sym_d;
            freq_cnt_q   <= freq_cnt_d;
            skid_valid_q <= skid_valid_d;
            skid_sym_q   <= skid_sym_d;
            skid_cnt_q   <= skid_cnt_d;
            blk_total_q  <= blk_total_d;
            ovf_q        <= ovf_d;
        end
    end

    assign huff_full  = huff_full_q;
    assign freq_valid = freq_valid_q;
    assign freq_sym   = freq_sym_q;
    assign freq_cnt   = freq_cnt_q;
    assign freq_last  = freq_valid_q && (freq_sym_q == 8'hFF);
    assign blk_total  = blk_total_q;
    assign ovf_err    = ovf_q;

endmodule : huff_freq_stat
`default_nettype wire

// File: tb/tb_huff_freq_stat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_huff_freq_stat                                          |
// | Brief    : Scoreboard bench for huff_freq_stat; counters narrowed to  |
// |            10 bits so saturation is reachable in a short run.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_huff_freq_stat;

    localparam int CW   = 10;
    localparam int TW   = 24;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [31:0]   huff_data = '0;
    logic          huff_valid = 1'b0;
    logic [2:0]    huff_lmask = 3'd4;
    logic          in_end = 1'b0;
    logic          huff_full;
    logic [7:0]    freq_sym;
    logic [CW-1:0] freq_cnt;
    logic          freq_valid;
    logic          freq_last;
    logic          freq_ready = 1'b1;
    logic [TW-1:0] blk_total;
    logic          ovf_err;

    always #5 clk = ~clk;

    huff_freq_stat #(.CNT_W(CW), .TOT_W(TW)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .huff_data  (huff_data),
        .huff_valid (huff_valid),
        .huff_lmask (huff_lmask),
        .in_end     (in_end),
        .huff_full  (huff_full),
        .freq_sym   (freq_sym),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid),
        .freq_last  (freq_last),
        .freq_ready (freq_ready),
        .blk_total  (blk_total),
        .ovf_err    (ovf_err)
    );

    typedef struct {
        logic [7:0]    sym;
        logic [CW-1:0] cnt;
        logic          last;
        logic [TW-1:0] tot;
    } exp_t;

    exp_t sb[$];
    int   model_cnt[256];
    int   model_tot;
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_cnt[i] = 0;
        model_tot = 0;
    endtask

    // Drives one word and folds its bytes into the model; an end word queues the full scan.
    task automatic send_word(input logic [31:0] d, input logic [2:0] m, input logic e);
        int w = 0;
        int n;
        logic [7:0] b;
        exp_t x;
        while (huff_full && w < 1000) begin
            tick();
            w++;
        end
        if (huff_full) begin
            checks++; errors++;
            $display("FAIL send_wait huff_full=%0b after %0d cycles, required 0", huff_full, w);
            return;
        end
        huff_data = d; huff_lmask = m; in_end = e; huff_valid = 1'b1;
        tick();
        huff_valid = 1'b0; in_end = 1'b0;
        n = (m >= 3'd1 && m <= 3'd4) ? int'(m) : 4;
        for (int i = 0; i < n; i++) begin
            b = d[31 - 8*i -: 8];
            if (model_cnt[b] < CMAX) model_cnt[b]++;
            if (model_tot < TMAX) model_tot++;
        end
        if (e) begin
            for (int s = 0; s < 256; s++) begin
                x.sym  = s[7:0];
                x.cnt  = model_cnt[s][CW-1:0];
                x.last = (s == 255);
                x.tot  = model_tot[TW-1:0];
                sb.push_back(x);
            end
            model_clear();
        end
    endtask

    // Pops the scoreboard on every transfer; first/lastc are cycle stamps relative to entry.
    task automatic collect_scan(input bit rnd, input int npairs, output int first, output int lastc);
        int got = 0;
        int cyc = 0;
        exp_t x;
        first = -1; lastc = -1;
        while (got < npairs && cyc < 4000) begin
            freq_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (freq_valid && freq_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scan_extra got sym=%0h cnt=%0h, required no pair", freq_sym, freq_cnt);
                end else begin
                    x = sb.pop_front();
                    if ({freq_sym, freq_cnt, freq_last, blk_total} !== {x.sym, x.cnt, x.last, x.tot}) begin
                        errors++;
                        $display("FAIL scan_pair got sym=%0h cnt=%0h last=%0b tot=%0d, required sym=%0h cnt=%0h last=%0b tot=%0d",
                                 freq_sym, freq_cnt, freq_last, blk_total, x.sym, x.cnt, x.last, x.tot);
                    end
                end
                if (first < 0) first = cyc;
                lastc = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        freq_ready = 1'b1;
        checks++;
        if (got != npairs) begin
            errors++;
            $display("FAIL scan_count got %0d transfers, required %0d", got, npairs);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        rstN = 1'b0;
        repeat (3) tick();
        checks++;
        if ({huff_full, freq_valid, freq_last, ovf_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got full/valid/last/ovf=%b, required 1000",
                     {huff_full, freq_valid, freq_last, ovf_err});
        end
        checks++;
        if ({freq_sym, freq_cnt, blk_total} !== '0) begin
            errors++;
            $display("FAIL reset_data got sym=%0h cnt=%0h tot=%0h, required 0", freq_sym, freq_cnt, blk_total);
        end
        rstN = 1'b1;
        while (huff_full && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 256 && n != 257) begin
            errors++;
            $display("FAIL clear_len huff_full fell after %0d clocks, required 256..257", n);
        end
    endtask

    task automatic test_single();
        int f, l;
        send_word(32'h41414141, 3'd4, 1'b1);
        collect_scan(1'b0, 256, f, l);
        checks++;
        if (f > 7) begin
            errors++;
            $display("FAIL first_latency got %0d cycles, required <= 7", f);
        end
        checks++;
        if (l - f != 255) begin
            errors++;
            $display("FAIL scan_rate got %0d cycles for 256 pairs, required 255", l - f);
        end
        checks++;
        if (huff_full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_scan got %0b, required 0", huff_full);
        end
    endtask

    task automatic test_mixed();
        int f, l;
        send_word(32'h01020304, 3'd2, 1'b0);
        send_word(32'h05050505, 3'd4, 1'b1);
        collect_scan(1'b0, 256, f, l);
    endtask

    task automatic test_back_to_back();
        int f, l;
        send_word(32'hFFFF00FF, 3'd4, 1'b0);
        send_word(32'hFF11FF22, 3'd4, 1'b1);
        collect_scan(1'b0, 256, f, l);
        send_word(32'h12345678, 3'd3, 1'b1);
        collect_scan(1'b0, 256, f, l);
    endtask

    task automatic test_ready_toggle();
        int f, l;
        send_word(32'h00000000, 3'd0, 1'b0);
        send_word(32'h80818283, 3'd7, 1'b0);
        send_word(32'hFEFE0101, 3'd1, 1'b0);
        for (int i = 0; i < 6; i++) send_word($urandom, 3'($urandom_range(0, 7)), 1'b0);
        send_word(32'hABCDABCD, 3'd4, 1'b1);
        collect_scan(1'b1, 256, f, l);
    endtask

    task automatic test_drop();
        int f, l;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before_drop got %0b, required 0", ovf_err);
        end
        send_word(32'h10203040, 3'd4, 1'b0);
        checks++;
        if (huff_full !== 1'b1) begin
            errors++;
            $display("FAIL full_busy got %0b, required 1", huff_full);
        end
        huff_data = 32'hAAAAAAAA; huff_lmask = 3'd4; huff_valid = 1'b1;
        tick();
        huff_valid = 1'b0;
        tick();
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got %0b, required 1", ovf_err);
        end
        send_word(32'h50000000, 3'd1, 1'b1);
        collect_scan(1'b0, 256, f, l);
    endtask

    task automatic test_reset_mid_scan();
        int f, l;
        send_word(32'h33333333, 3'd4, 1'b1);
        collect_scan(1'b0, 40, f, l);
        rstN = 1'b0;
        #1;
        checks++;
        if ({huff_full, freq_valid, freq_last, ovf_err} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_flags got full/valid/last/ovf=%b, required 1000",
                     {huff_full, freq_valid, freq_last, ovf_err});
        end
        checks++;
        if ({freq_sym, freq_cnt, blk_total} !== '0) begin
            errors++;
            $display("FAIL midrst_data got sym=%0h cnt=%0h tot=%0h, required 0", freq_sym, freq_cnt, blk_total);
        end
        tick();
        tick();
        rstN = 1'b1;
        sb.delete();
        model_clear();
        send_word(32'h33447733, 3'd4, 1'b1);
        collect_scan(1'b0, 256, f, l);
    endtask

    task automatic test_saturation();
        int f, l;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before_sat got %0b, required 0", ovf_err);
        end
        for (int i = 0; i < 274; i++) send_word(32'h00000000, 3'd4, 1'b0);
        send_word(32'h00000000, 3'd4, 1'b1);
        collect_scan(1'b0, 256, f, l);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat got %0b, required 1", ovf_err);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_mixed();
        test_back_to_back();
        test_ready_toggle();
        test_drop();
        test_reset_mid_scan();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_huff_freq_stat
`default_nettype wire
